// File: rtl/picomips_sequencer_if.sv
// picomips_sequencer_if
//   Groups the switch-side controls, the pc / prog_mem address pair and the
//   per-instruction enables exchanged between the picoMIPS top level and the
//   instruction sequencer.
//
//   master : the top level (drives run, step, pc_addr, next_addr; observes
//            exec_en, fetch_en, step_ack, busy, halted, instr_count)
//   slave  : the sequencer (the opposite directions)
//
//   run         level, free-run request
//   step        level from switch/button, each rising edge requests one instr
//   pc_addr     address of the instruction currently presented by prog_mem
//   next_addr   address selected by the pc block for the current instruction
//   exec_en     register-file write enable pulse
//   fetch_en    program-memory enable pulse
//   step_ack    stepped instruction completed pulse
//   busy        sequencer in EXEC or FETCH
//   halted      sequencer in HALT
//   instr_count retired-instruction counter (zero unless the counter is built)
interface picomips_sequencer_if #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 run;
  logic                 step;
  logic [PC_WIDTH-1:0]  pc_addr;
  logic [PC_WIDTH-1:0]  next_addr;
  logic                 exec_en;
  logic                 fetch_en;
  logic                 step_ack;
  logic                 busy;
  logic                 halted;
  logic [CNT_WIDTH-1:0] instr_count;

  modport master (
    output run, step, pc_addr, next_addr,
    input  exec_en, fetch_en, step_ack, busy, halted, instr_count
  );

  modport slave (
    input  run, step, pc_addr, next_addr,
    output exec_en, fetch_en, step_ack, busy, halted, instr_count
  );
endinterface

// File: rtl/picomips_sequencer.sv
// picomips_sequencer
//   Controlled instruction sequencer for picoMIPS. Each instruction takes an
//   EXEC cycle (register write-back, exec_en) followed by a FETCH cycle
//   (prog_mem latches next_addr, fetch_en). Supports free-run, single-step
//   with acknowledge and a sticky halt when an instruction branches to itself.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    picomips_sequencer_if.slave (run, step, pc_addr, next_addr in;
//            exec_en, fetch_en, step_ack, busy, halted, instr_count out)
//
//   Parameters:
//     PC_WIDTH    program-memory address width
//     HALT_DETECT 1 = halt when next_addr == pc_addr during EXEC
//     CNT_WIDTH   width of instr_count
//
//   Optional feature macro: PICOMIPS_SEQ_INSTR_COUNT_EN
//     defined   -> saturating retired-instruction counter on instr_count
//     undefined -> no counter register, instr_count tied to zero
module picomips_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int HALT_DETECT = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  picomips_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, FETCH, HALT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                step_q;
  logic                step_mode;
  logic                step_mode_nxt;
  logic                step_rise;
  logic                self_loop;
  logic [PC_WIDTH-1:0] pc_now;
  logic [PC_WIDTH-1:0] pc_nxt;

  logic                exec_en_q;
  logic                fetch_en_q;
  logic                step_ack_q;
  logic                busy_q;
  logic                halted_q;

  assign pc_now    = bus.pc_addr;
  assign pc_nxt    = bus.next_addr;
  assign self_loop = (HALT_DETECT != 0) && (pc_nxt == pc_now);
  assign step_rise = bus.step & ~step_q;

  always_comb begin
    state_nxt     = state;
    step_mode_nxt = step_mode;
    case (state)
      IDLE: begin
        // run wins over a simultaneous step edge
        if (bus.run) begin
          state_nxt     = EXEC;
          step_mode_nxt = 1'b0;
        end else if (step_rise) begin
          state_nxt     = EXEC;
          step_mode_nxt = 1'b1;
        end
      end
      EXEC: begin
        // an instruction that jumps to itself would spin forever, so stop
        // after its write-back instead of refetching the same address
        if (self_loop) state_nxt = HALT;
        else           state_nxt = FETCH;
      end
      FETCH: begin
        // a stepped instruction always returns to IDLE so step_ack is seen;
        // a run request raised meanwhile is picked up from IDLE
        if (step_mode)    state_nxt = IDLE;
        else if (bus.run) state_nxt = EXEC;
        else              state_nxt = IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are one-hot decodes
  // of the state actually held, with no combinational path to the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step_q     <= 1'b0;
      step_mode  <= 1'b0;
      exec_en_q  <= 1'b0;
      fetch_en_q <= 1'b0;
      step_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_q     <= bus.step;
      step_mode  <= step_mode_nxt;
      exec_en_q  <= (state_nxt == EXEC);
      fetch_en_q <= (state_nxt == FETCH);
      step_ack_q <= (state_nxt == FETCH) && step_mode_nxt;
      busy_q     <= (state_nxt == EXEC) || (state_nxt == FETCH);
      halted_q   <= (state_nxt == HALT);
    end
  end

  assign bus.exec_en  = exec_en_q;
  assign bus.fetch_en = fetch_en_q;
  assign bus.step_ack = step_ack_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;

`ifdef PICOMIPS_SEQ_INSTR_COUNT_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [CNT_WIDTH-1:0] count_q;

  // one retirement per cycle in which exec_en is high
  always_ff @(posedge clk) begin
    if (reset)          count_q <= '0;
    else if (exec_en_q) count_q <= sat_inc(count_q);
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_picomips_sequencer.sv
// tb_picomips_sequencer
//   Directed scenarios followed by randomized run/step/address/reset traffic,
//   every cycle compared against a behavioural model of the sequencer.
module tb_picomips_sequencer;
  localparam int PW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  picomips_sequencer_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  picomips_sequencer #(.PC_WIDTH(PW), .HALT_DETECT(1), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  // Model: what the current instruction slot is doing.
  // 0 = nothing in flight, 1 = write-back cycle, 2 = fetch cycle, 3 = halted.
  int slot = 0;
  bit stepped = 1'b0;   // current instruction was started by a step edge
  bit prev_step = 1'b0;
  int retired = 0;
  int exec_seen = 0;
  int fetch_seen = 0;
  int ack_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    int  nslot;
    bit  nstepped;
    bit  edge_seen;
    nslot    = slot;
    nstepped = stepped;
    if (reset) begin
      nslot     = 0;
      nstepped  = 1'b0;
      prev_step = 1'b0;
      retired   = 0;
    end else begin
      edge_seen = bus.step && !prev_step;
      prev_step = bus.step;
`ifdef PICOMIPS_SEQ_INSTR_COUNT_EN
      if (slot == 1 && retired < (1 << CW) - 1) retired = retired + 1;
`endif
      if (slot == 0) begin
        if (bus.run) begin nslot = 1; nstepped = 1'b0; end
        else if (edge_seen) begin nslot = 1; nstepped = 1'b1; end
      end else if (slot == 1) begin
        nslot = (bus.next_addr == bus.pc_addr) ? 3 : 2;
      end else if (slot == 2) begin
        nslot = (!stepped && bus.run) ? 1 : 0;
      end
    end
    slot    = nslot;
    stepped = nstepped;
    @(posedge clk);
    #1;
    chk("exec_en",     32'(bus.exec_en),     32'(slot == 1));
    chk("fetch_en",    32'(bus.fetch_en),    32'(slot == 2));
    chk("step_ack",    32'(bus.step_ack),    32'(slot == 2 && stepped));
    chk("busy",        32'(bus.busy),        32'(slot == 1 || slot == 2));
    chk("halted",      32'(bus.halted),      32'(slot == 3));
    chk("instr_count", 32'(bus.instr_count), 32'(retired));
    exec_seen  += int'(bus.exec_en);
    fetch_seen += int'(bus.fetch_en);
    ack_seen   += int'(bus.step_ack);
  endtask

  task automatic clear_tallies();
    exec_seen = 0; fetch_seen = 0; ack_seen = 0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.run       = 1'b0;
    bus.step      = 1'b0;
    bus.pc_addr   = 8'h10;
    bus.next_addr = 8'h11;
    tick(); tick();

    // Idle after reset release
    reset = 1'b0;
    clear_tallies();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_exec_cnt", 32'(exec_seen), 32'd0);

    // Free-run for 8 cycles: 4 instructions
    bus.run = 1'b1;
    tick();
    clear_tallies();
    for (int i = 0; i < 8; i++) tick();
    chk("run8_exec", 32'(exec_seen), 32'd4);
    chk("run8_fetch", 32'(fetch_seen), 32'd4);
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Single step held high: exactly one instruction
    clear_tallies();
    bus.step = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("step1_exec", 32'(exec_seen), 32'd1);
    chk("step1_fetch", 32'(fetch_seen), 32'd1);
    chk("step1_ack", 32'(ack_seen), 32'd1);
    bus.step = 1'b0; tick(); tick();
    clear_tallies();
    bus.step = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.step = 1'b0;
    chk("step2_exec", 32'(exec_seen), 32'd1);

    // Run asserted during a stepped instruction
    tick();
    bus.step = 1'b1; tick();
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.run = 1'b0; bus.step = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Halt on self-loop at the third instruction
    reset = 1'b1; tick(); reset = 1'b0;
    bus.pc_addr = 8'h05; bus.next_addr = 8'h06;
    clear_tallies();
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) bus.next_addr = 8'h05;
      tick();
    end
    chk("halt_exec", 32'(exec_seen), 32'd3);
    chk("halt_fetch", 32'(fetch_seen), 32'd2);
    for (int i = 0; i < 20; i++) begin
      bus.run  = 1'($urandom_range(0, 1));
      bus.step = 1'($urandom_range(0, 1));
      tick();
    end
    chk("halt_sticky", 32'(bus.halted), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    bus.run = 1'b0; bus.step = 1'b0;
    bus.next_addr = 8'h06;
    tick();

    // Reset while in EXEC
    bus.run = 1'b1;
    tick();
    chk("in_exec", 32'(bus.exec_en), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    bus.run = 1'b0;
    tick(); tick();

    // Long free-run to saturate the counter
    bus.run = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    bus.run = 1'b0;
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 3) == 0) bus.step = ~bus.step;
      bus.pc_addr   = 8'($urandom);
      bus.next_addr = ($urandom_range(0, 15) == 0) ? bus.pc_addr : 8'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/picomips_sequencer.md
Name: picomips_sequencer

Overview:
- Replaces the free-running cycle generator in the picoMIPS top level with a controlled instruction sequencer.
- Generates the two per-instruction enables: exec_en drives the register-file write enable, fetch_en drives the program-memory enable.
- Supports free-run, single-step with acknowledge, and halt-on-self-loop detection.
- Sits between the top-level switches and the pc / prog_mem / regs instances.

Parameters:
- PC_WIDTH, 8, width of program-memory address (matches PROG_MEM_ADDR_WIDTH).
- HALT_DETECT, 1, 1 = enter HALT when an executed instruction's next address equals its own address; 0 = never halt.
- CNT_WIDTH, 16, width of instr_count (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; high = execute instructions back to back
- step  in  1  level from switch/button; each rising edge requests one instruction
- pc_addr  in  PC_WIDTH  address of the instruction currently presented by prog_mem
- next_addr  in  PC_WIDTH  address selected by the pc block (branch or normal) for the current instruction
- exec_en  out  1  one-cycle pulse; register write-back for the current instruction
- fetch_en  out  1  one-cycle pulse; prog_mem latches next_addr
- step_ack  out  1  one-cycle pulse; a stepped instruction has completed
- busy  out  1  high in EXEC or FETCH
- halted  out  1  high in HALT
- instr_count  out  CNT_WIDTH  retired-instruction counter (optional feature only)

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock (clk); reset is synchronous and active-high.
  - Reset forces state IDLE, clears step_q and step_mode, and clears instr_count.
  - All outputs are 0 in the cycle after reset is sampled high.
  - Reset mid-instruction abandons the instruction; a pending fetch_en is not issued.
- States: IDLE, EXEC, FETCH, HALT.
  - One-hot outputs: exec_en = (state==EXEC), fetch_en = (state==FETCH), busy = EXEC|FETCH, halted = (state==HALT).
- Step edge:
  - step_q is a registered copy of step.
  - step_rise = step & ~step_q, evaluated every cycle.
- IDLE:
  - run=1 -> EXEC, step_mode=0.
  - Else step_rise=1 -> EXEC, step_mode=1.
  - Else stay.
  - run has priority when both occur in the same cycle.
- EXEC (1 cycle):
  - If HALT_DETECT=1 and next_addr==pc_addr -> HALT; no fetch_en is issued because the address is unchanged.
  - Otherwise -> FETCH.
- FETCH (1 cycle):
  - If step_mode=1 -> IDLE and pulse step_ack in this same cycle.
  - Else if run=1 -> EXEC.
  - Else -> IDLE.
- Instruction latency: 2 cycles (EXEC, FETCH). In free-run, throughput is 1 instruction per 2 cycles, with no bubble.
- Step edges seen while not in IDLE are dropped; they are neither queued nor counted.
- Deasserting run mid-instruction lets the current EXEC+FETCH finish, then the block idles.
- Asserting run during a stepped instruction:
  - The stepped instruction still completes and still pulses step_ack.
  - The block then returns to IDLE and enters free-run on the next cycle.
- HALT:
  - The instruction that caused the halt has written back (exec_en was pulsed once).
  - HALT is sticky: run and step are ignored and only reset leaves it.
- exec_en and fetch_en are never high in the same cycle.

Optional Feature:
- Macro PICOMIPS_SEQ_INSTR_COUNT_EN.
- When defined:
  - instr_count increments by 1 in every cycle where exec_en=1.
  - It saturates at all-ones with no wrap.
  - It is cleared by reset.
- When undefined:
  - The counter register is not built.
  - instr_count is tied to 0.

Test Plan:
- Reset release with run=0, step=0 for 10 cycles -> exec_en=fetch_en=busy=halted=step_ack=0 throughout.
- run=1 held for 8 cycles after IDLE, pc_addr!=next_addr -> exec_en pattern 1,0,1,0,1,0,1,0; fetch_en is the complement; instr_count=4 (feature on).
- step 0->1 held high 20 cycles, run=0 -> exactly one exec_en, one fetch_en, and step_ack on the fetch cycle; then IDLE; a second 0->1 edge gives one more instruction.
- run=1, pc_addr=0x05, next_addr=0x05 on the 3rd instruction -> 3 exec_en pulses, 2 fetch_en pulses, halted=1 and stays 1 for 20 cycles despite run and step toggling; reset returns to IDLE.
- Assert reset in the cycle the block is in EXEC -> next cycle IDLE with all outputs 0, no fetch_en; instr_count=0.
- Feature on with CNT_WIDTH=4, run=1 for 40 cycles -> instr_count reaches 15 and holds 15.
